sprite_rom_arbiter: RTL
=======================

# sprite_rom_arbiter

Shares the single-port sprite ROM (synchronous read, 10-bit address, 12-bit pixel word) among several pixel-fetch requesters, e.g. fruit, blade-trail and score renderers. Each cycle the block grants at most one pending request and drives the ROM address. It tracks the ROM read latency with a tag pipeline and returns the word only to the requester that asked for it. It sits between the renderers and the `memoryRead` ROM wrapper.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 10: ROM address width.
- `DATA_W`, 12: ROM data width (RGB444).
- `ROM_LAT`, 1: ROM read latency in cycles, from address registered at the ROM input to `douta` valid (1..3).

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: per-requester request level.
- `addr_in` in `NUM_REQ*ADDR_W`: packed request addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `gnt` out `NUM_REQ`: registered one-hot grant pulse; zero or one bit set.
- `rvalid` out `NUM_REQ`: registered one-hot return pulse.
- `rdata` out `DATA_W`: return word, valid while any `rvalid` bit is high.
- `busy` out 1: high while any granted read has not yet returned.
- `rom_addr` out `ADDR_W`: to ROM `addra`.
- `rom_data` in `DATA_W`: from ROM `douta`.

## Operation
- Arbitration is combinational over `req`. The winner is registered into `gnt` and `rom_addr`.
- Round-robin pointer `ptr`: search starts at index `ptr` and wraps modulo `NUM_REQ`. After granting index i, `ptr` becomes (i+1) mod `NUM_REQ`. With no grant, `ptr` is unchanged.
- Requester protocol:
  - Hold `req` and the address stable until it sees `gnt[i]`.
  - Drop `req` in the cycle after the grant unless it wants another word.
  - If `req[i]` stays high the cycle after the grant, that is a new request and it is arbitrated normally.
- Tag pipeline: a shift register of `ROM_LAT+1` one-hot tags. The stage-0 tag is `gnt`. When the tag reaches the final stage, the block registers `rvalid` <= tag and `rdata` <= `rom_data`.
- Sustained throughput is one grant per cycle. The tags handle any number of reads in flight; no backpressure is applied on return.
- `rom_addr` holds its last value when nothing is granted.
- `rdata` holds its last value when `rvalid` is 0.
- `busy` = OR of all tag stages.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `rom_addr`=0, `busy`=0, `ptr`=0, all tags 0.
- Request seen in cycle t (req high before edge t):
  - `gnt` and `rom_addr` valid in cycle t+1.
  - ROM data valid at t+1+`ROM_LAT`.
  - `rvalid`/`rdata` in cycle t+2+`ROM_LAT` (t+3 for the default).
- Back-to-back grants return in grant order, one per cycle, with the same fixed latency.
- Simultaneous requests: exactly one winner per cycle. The losers stay pending with no loss.
- A single requester that holds `req` high continuously is granted every cycle.
- Reset asserted mid-operation: all in-flight tags are discarded immediately (asynchronously) and no `rvalid` is produced for them. Arbitration after reset starts from index 0.
- `req` deasserted before a grant cancels the request silently.

## Configuration
- `SPRITE_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. `ptr` is removed and the search always starts at 0.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Reset, then single request: `req`=0001, `addr_in[0]`=10'h005, ROM word 12'hF0A at address 5 -> `gnt`=0001 in cycle 1, `rom_addr`=10'h005, `rvalid`=0001 and `rdata`=12'hF0A in cycle 3; `busy` high in cycles 1-2.
- All four requesting continuously from reset -> grant order 0,1,2,3,0,…; each `rvalid` pulse is 2 cycles after its grant with the matching ROM word.
- Requests 1 and 3 held, `ptr`=2 -> grants 3 then 1, then `ptr`=2.
- `rst_n` pulsed low one cycle after a grant -> no `rvalid` ever appears for that grant; all outputs are 0 during reset.
- `SPRITE_ARB_FIXED_PRIO_EN` defined, requests 0 and 2 held -> `gnt`=0001 every cycle and requester 2 is never granted; it is granted in the first cycle after `req[0]` drops.
- `ROM_LAT`=2 build, back-to-back grants to 0 then 1 at cycles 1 and 2 -> `rvalid`=0001 at cycle 4 and 0010 at cycle 5, with the correct words.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//   Shares one synchronous single-port sprite ROM among NUM_REQ pixel-fetch
//   requesters. At most one pending request is granted per cycle. The grant
//   travels down a one-hot tag pipeline that matches the ROM read latency, so
//   each returned word goes only to the requester that asked for it.
//
//   Build option: define SPRITE_ARB_FIXED_PRIO_EN for fixed priority, where
//   the lowest index wins and there is no rotating pointer. By default the
//   arbiter is round-robin.
//
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset
//     req       per-requester request level
//     addr_in   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//     gnt       registered one-hot grant pulse
//     rvalid    registered one-hot return pulse
//     rdata     returned ROM word, held between returns
//     busy      high while any granted read is still in flight
//     rom_addr  ROM address (addra), held when idle
//     rom_data  ROM read data (douta)
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // (base + step) modulo NUM_REQ; step never exceeds NUM_REQ-1 here, so a
  // single conditional subtract is enough.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int step);
    int sum_v;
    sum_v = int'(base) + step;
    if (sum_v >= NUM_REQ) begin
      sum_v = sum_v - NUM_REQ;
    end else begin
      sum_v = sum_v;
    end
    return sum_v[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0]   start_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               win_found_s;
  logic [NUM_REQ-1:0] win_onehot_s;
  logic               inflight_s;

  // Stage 0 is the grant itself; stage ROM_LAT lines up with valid douta.
  logic [NUM_REQ-1:0] tag_r [ROM_LAT+1];
  logic [NUM_REQ-1:0] rvalid_r;
  logic [DATA_W-1:0]  rdata_r;
  logic               busy_r;
  logic [ADDR_W-1:0]  rom_addr_r;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign start_s = '0;
`else
  logic [IDX_W-1:0] ptr_r;

  assign start_s = ptr_r;

  // Round-robin pointer: advance past the winner, hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (win_found_s) begin
      ptr_r <= wrap_add(win_idx_s, 1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Arbitration: first active request found searching upward from start_s.
  always_comb begin
    win_found_s  = 1'b0;
    win_idx_s    = '0;
    win_onehot_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found_s && req[wrap_add(start_s, k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = wrap_add(start_s, k);
      end else begin
        win_found_s = win_found_s;
      end
    end
    if (win_found_s) begin
      win_onehot_s[win_idx_s] = 1'b1;
    end else begin
      win_onehot_s = '0;
    end
  end

  // Any tag in a stage that will still exist after the next shift.
  always_comb begin
    inflight_s = 1'b0;
    for (int s = 0; s < ROM_LAT; s++) begin
      inflight_s = inflight_s | (|tag_r[s]);
    end
  end

  // Grant/address registers, tag shift and return capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= ROM_LAT; s++) begin
        tag_r[s] <= '0;
      end
      rvalid_r   <= '0;
      rdata_r    <= '0;
      busy_r     <= 1'b0;
      rom_addr_r <= '0;
    end else begin
      tag_r[0] <= win_onehot_s;
      for (int s = 1; s <= ROM_LAT; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
      if (win_found_s) begin
        rom_addr_r <= addr_in[int'(win_idx_s)*ADDR_W +: ADDR_W];
      end else begin
        rom_addr_r <= rom_addr_r;
      end
      rvalid_r <= tag_r[ROM_LAT];
      if (|tag_r[ROM_LAT]) begin
        rdata_r <= rom_data;
      end else begin
        rdata_r <= rdata_r;
      end
      // busy reflects the OR of the tag stages as they will be next cycle.
      busy_r <= (|win_onehot_s) | inflight_s;
    end
  end

  assign gnt      = tag_r[0];
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign busy     = busy_r;
  assign rom_addr = rom_addr_r;

endmodule
